lpc_io_sequencer: RTL and testbench

LPC_IO_SEQUENCER -- requirements
Module: lpc_io_sequencer

---
 rtl/lpc_io_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_lpc_io_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_sequencer.sv
// lpc_io_sequencer
// LPC I/O target for one 8-byte window at BASE_ADDR (bits [2:0] ignored).
// It decodes IORD/IOWR cycles on LAD and turns each matched cycle into a
// single register access (reg_req/reg_ack handshake). While waiting it
// drives SYNC short-wait, then ready, then the read data if any, and
// finally the turnaround nibble back to the host.
//
// Optional build macro: LPC_SEQ_TIMEOUT_EN. When defined, a SYNC wait that
// lasts TIMEOUT cycles without an ack drops reg_req and answers with SYNC
// error (4'hA) followed by the turnaround. When undefined, SYNC waits forever.
//
// Ports
//   lpc_clk     in   clock, rising edge
//   lpc_rst     in   async active-high reset
//   lpc_frame   in   LFRAME#, active low
//   lpc_ad_in   in   LAD[3:0] sampled from the bus
//   lpc_ad_out  out  LAD value while lpc_ad_oe=1
//   lpc_ad_oe   out  LAD output enable
//   reg_req     out  register access request, held until acked
//   reg_we      out  1=write, 0=read
//   reg_addr    out  register offset
//   reg_wdata   out  write data
//   reg_ack     in   access complete
//   reg_rdata   in   read data, valid with reg_ack
//
// state | meaning
// IDLE  | waiting for START (frame low, LAD=0)
// CTDIR | cycle type / direction nibble
// ADDR  | four address nibbles, MSN first
// WDATA | two write data nibbles, low first
// TAR1  | host turnaround, first cycle
// TAR2  | host turnaround, second cycle
// SYNC  | 5 until acked, then 0 for one cycle (A on timeout)
// RDATA | two read data nibbles, low first
// HTAR  | drive F for one cycle, then release
module lpc_io_sequencer #(
    parameter logic [15:0] BASE_ADDR = 16'h03F8,
    parameter int          TIMEOUT   = 15
) (
    input  logic       lpc_clk,
    input  logic       lpc_rst,
    input  logic       lpc_frame,
    input  logic [3:0] lpc_ad_in,
    output logic [3:0] lpc_ad_out,
    output logic       lpc_ad_oe,
    output logic       reg_req,
    output logic       reg_we,
    output logic [2:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic       reg_ack,
    input  logic [7:0] reg_rdata
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CTDIR = 4'd1;
    localparam logic [3:0] S_ADDR  = 4'd2;
    localparam logic [3:0] S_WDATA = 4'd3;
    localparam logic [3:0] S_TAR1  = 4'd4;
    localparam logic [3:0] S_TAR2  = 4'd5;
    localparam logic [3:0] S_SYNC  = 4'd6;
    localparam logic [3:0] S_RDATA = 4'd7;
    localparam logic [3:0] S_HTAR  = 4'd8;

    logic [3:0]  state;
    logic [1:0]  nib_cnt;
    logic [11:0] addr_sr;
    logic [15:0] addr_full;
    logic        is_write;
    logic        ack_seen;
    logic [7:0]  rdata_q;
    logic        timed_out;
    logic        tmr_tc;

    assign addr_full = {addr_sr, lpc_ad_in};

`ifdef LPC_SEQ_TIMEOUT_EN
    logic [15:0] tmr;

    // Terminal count on the last short-wait cycle; an ack on the same edge wins.
    assign tmr_tc = (state == S_SYNC) && lpc_frame && !ack_seen && !timed_out &&
                    !(reg_req && reg_ack) && (tmr == 16'd1);

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            tmr       <= '0;
            timed_out <= 1'b0;
        end else if (!lpc_frame || state == S_TAR1) begin
            tmr       <= 16'(TIMEOUT);
            timed_out <= 1'b0;
        end else if (state == S_SYNC && !ack_seen && !timed_out && !(reg_req && reg_ack)) begin
            if (tmr_tc) begin
                timed_out <= 1'b1;
            end else begin
                tmr <= tmr - 16'd1;
            end
        end
    end
`else
    assign tmr_tc    = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            state     <= S_IDLE;
            nib_cnt   <= '0;
            addr_sr   <= '0;
            is_write  <= 1'b0;
            ack_seen  <= 1'b0;
            rdata_q   <= '0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            if (reg_req && reg_ack) begin
                reg_req  <= 1'b0;
                rdata_q  <= reg_rdata;
                ack_seen <= 1'b1;
            end
            if (tmr_tc) begin
                reg_req <= 1'b0;
            end
            // Frame low aborts whatever is in flight and is treated as a
            // START candidate, so the last nibble before frame rises wins.
            if (!lpc_frame) begin
                reg_req  <= 1'b0;
                ack_seen <= 1'b0;
                state    <= (lpc_ad_in == 4'h0) ? S_CTDIR : S_IDLE;
            end else begin
                case (state)
                    S_CTDIR: begin
                        nib_cnt <= '0;
                        if (lpc_ad_in == 4'h0 || lpc_ad_in == 4'h2) begin
                            is_write <= lpc_ad_in[1];
                            reg_we   <= lpc_ad_in[1];
                            state    <= S_ADDR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_ADDR: begin
                        addr_sr <= {addr_sr[7:0], lpc_ad_in};
                        nib_cnt <= nib_cnt + 2'd1;
                        if (nib_cnt == 2'd3) begin
                            nib_cnt <= '0;
                            if (addr_full[15:3] != BASE_ADDR[15:3]) begin
                                state <= S_IDLE;
                            end else begin
                                reg_addr <= lpc_ad_in[2:0];
                                if (is_write) begin
                                    state <= S_WDATA;
                                end else begin
                                    state    <= S_TAR1;
                                    reg_req  <= 1'b1;
                                    ack_seen <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WDATA: begin
                        if (nib_cnt == 2'd0) begin
                            reg_wdata[3:0] <= lpc_ad_in;
                            nib_cnt        <= 2'd1;
                        end else begin
                            reg_wdata[7:4] <= lpc_ad_in;
                            nib_cnt        <= '0;
                            state          <= S_TAR1;
                            reg_req        <= 1'b1;
                            ack_seen       <= 1'b0;
                        end
                    end
                    S_TAR1: state <= S_TAR2;
                    S_TAR2: state <= S_SYNC;
                    S_SYNC: begin
                        // ack_seen/timed_out are registered, so the ready or
                        // error nibble is always driven for one full cycle.
                        if (timed_out) begin
                            state <= S_HTAR;
                        end else if (ack_seen) begin
                            nib_cnt <= '0;
                            state   <= is_write ? S_HTAR : S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        nib_cnt <= nib_cnt + 2'd1;
                        if (nib_cnt != 2'd0) begin
                            state <= S_HTAR;
                        end
                    end
                    S_HTAR:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Driven from state only, so reset releases LAD without a clock edge.
    assign lpc_ad_oe = (state == S_SYNC) || (state == S_RDATA) || (state == S_HTAR);

    always_comb begin
        lpc_ad_out = 4'hF;
        case (state)
            S_SYNC: begin
                if (timed_out) begin
                    lpc_ad_out = 4'hA;
                end else if (ack_seen) begin
                    lpc_ad_out = 4'h0;
                end else begin
                    lpc_ad_out = 4'h5;
                end
            end
            S_RDATA: lpc_ad_out = (nib_cnt == 2'd0) ? rdata_q[3:0] : rdata_q[7:4];
            default: lpc_ad_out = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_lpc_io_sequencer.sv
// tb_lpc_io_sequencer
// Directed LPC I/O cycles against lpc_io_sequencer with a simple peripheral
// that acks a programmable number of cycles after reg_req rises. Every LAD
// nibble driven by the DUT is logged and compared with a hand-built list.
module tb_lpc_io_sequencer;

    logic       lpc_clk = 1'b0;
    logic       lpc_rst = 1'b1;
    logic       lpc_frame = 1'b1;
    logic [3:0] lpc_ad_in = 4'hF;
    logic [3:0] lpc_ad_out;
    logic       lpc_ad_oe;
    logic       reg_req;
    logic       reg_we;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack = 1'b0;
    logic [7:0] reg_rdata = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    int         ack_delay = 0;
    logic [7:0] rd_val = 8'h00;
    int         req_cycles = 0;

    logic [3:0] lad_q[$];
    logic [3:0] exp_q[$];
    int         req_cnt = 0;
    logic       req_d = 1'b0;
    logic       cap_we;
    logic [2:0] cap_addr;
    logic [7:0] cap_wdata;

    lpc_io_sequencer dut (
        .lpc_clk    (lpc_clk),
        .lpc_rst    (lpc_rst),
        .lpc_frame  (lpc_frame),
        .lpc_ad_in  (lpc_ad_in),
        .lpc_ad_out (lpc_ad_out),
        .lpc_ad_oe  (lpc_ad_oe),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_ack    (reg_ack),
        .reg_rdata  (reg_rdata)
    );

    always #5 lpc_clk = ~lpc_clk;

    // Peripheral: ack in the (ack_delay+1)-th cycle of reg_req.
    always @(negedge lpc_clk) begin
        if (reg_req) begin
            if (req_cycles == ack_delay) begin
                reg_ack   = 1'b1;
                reg_rdata = rd_val;
            end
            req_cycles++;
        end else begin
            reg_ack    = 1'b0;
            req_cycles = 0;
        end
    end

    // Bus monitor: LAD log and request capture.
    always @(negedge lpc_clk) begin
        if (lpc_ad_oe) lad_q.push_back(lpc_ad_out);
        if (reg_req && !req_d) begin
            req_cnt++;
            cap_we    = reg_we;
            cap_addr  = reg_addr;
            cap_wdata = reg_wdata;
        end
        req_d = reg_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [3:0] n);
        @(negedge lpc_clk);
        lpc_frame = f;
        lpc_ad_in = n;
    endtask

    task automatic clear_log();
        lad_q.delete();
        exp_q.delete();
        req_cnt   = 0;
        cap_we    = 1'bx;
        cap_addr  = 3'bx;
        cap_wdata = 8'hxx;
    endtask

    // Everything after the START nibble, then idle long enough to finish.
    task automatic host_tail(input logic wr, input logic [15:0] a, input logic [7:0] wd);
        drive(1'b1, wr ? 4'h2 : 4'h0);
        drive(1'b1, a[15:12]);
        drive(1'b1, a[11:8]);
        drive(1'b1, a[7:4]);
        drive(1'b1, a[3:0]);
        if (wr) begin
            drive(1'b1, wd[3:0]);
            drive(1'b1, wd[7:4]);
        end
        for (int i = 0; i < 50; i++) drive(1'b1, 4'hF);
    endtask

    task automatic host_io(input logic wr, input logic [15:0] a, input logic [7:0] wd);
        drive(1'b0, 4'h0);
        host_tail(wr, a, wd);
    endtask

    task automatic check_lad(input string tag);
        chk({tag, "_len"}, lad_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < lad_q.size(); i++)
            chk($sformatf("%s_lad%0d", tag, i), {28'h0, lad_q[i]}, {28'h0, exp_q[i]});
    endtask

    initial begin
        // Reset state
        #23;
        chk("rst_oe",    lpc_ad_oe,  0);
        chk("rst_out",   lpc_ad_out, 32'hF);
        chk("rst_req",   reg_req,    0);
        chk("rst_we",    reg_we,     0);
        chk("rst_addr",  reg_addr,   0);
        chk("rst_wdata", reg_wdata,  0);
        @(negedge lpc_clk);
        lpc_rst = 1'b0;

        // IOWR 0x3F8 <- 0x5A, ack in TAR1
        clear_log();
        ack_delay = 0;
        host_io(1'b1, 16'h03F8, 8'h5A);
        exp_q = '{4'h0, 4'hF};
        check_lad("wr3f8");
        chk("wr3f8_reqs",  req_cnt,   1);
        chk("wr3f8_we",    cap_we,    1);
        chk("wr3f8_addr",  cap_addr,  0);
        chk("wr3f8_wdata", cap_wdata, 32'h5A);

        // IORD 0x3FD, ack after 3 cycles, data 0x61
        clear_log();
        ack_delay = 3;
        rd_val    = 8'h61;
        host_io(1'b0, 16'h03FD, 8'h00);
        exp_q = '{4'h5, 4'h5, 4'h0, 4'h1, 4'h6, 4'hF};
        check_lad("rd3fd");
        chk("rd3fd_reqs", req_cnt,  1);
        chk("rd3fd_we",   cap_we,   0);
        chk("rd3fd_addr", cap_addr, 5);

        // IORD outside the window
        clear_log();
        host_io(1'b0, 16'h02F8, 8'h00);
        check_lad("rd2f8");
        chk("rd2f8_reqs", req_cnt, 0);

        // IORD 0x3F8 right after, ack in TAR2, data 0x3C
        clear_log();
        ack_delay = 1;
        rd_val    = 8'h3C;
        host_io(1'b0, 16'h03F8, 8'h00);
        exp_q = '{4'h0, 4'hC, 4'h3, 4'hF};
        check_lad("rd3f8");
        chk("rd3f8_reqs", req_cnt,  1);
        chk("rd3f8_addr", cap_addr, 0);

        // Frame low with START during the 2nd address nibble restarts
        clear_log();
        ack_delay = 2;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h2);
        drive(1'b1, 4'h0);
        drive(1'b0, 4'h0);
        host_tail(1'b1, 16'h03F9, 8'hA5);
        exp_q = '{4'h5, 4'h0, 4'hF};
        check_lad("abort");
        chk("abort_reqs",  req_cnt,   1);
        chk("abort_addr",  cap_addr,  1);
        chk("abort_wdata", cap_wdata, 32'hA5);

        // Reset pulse during SYNC wait
        clear_log();
        ack_delay = 1000;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h3);
        drive(1'b1, 4'hF);
        drive(1'b1, 4'hD);
        for (int i = 0; i < 6; i++) drive(1'b1, 4'hF);
        chk("pre_rst_oe", lpc_ad_oe, 1);
        @(posedge lpc_clk);
        #3 lpc_rst = 1'b1;
        #1;
        chk("async_rst_oe",  lpc_ad_oe, 0);
        chk("async_rst_req", reg_req,   0);
        @(negedge lpc_clk);
        lpc_rst = 1'b0;
        clear_log();
        ack_delay = 0;
        rd_val    = 8'h7E;
        host_io(1'b0, 16'h03FD, 8'h00);
        exp_q = '{4'h0, 4'hE, 4'h7, 4'hF};
        check_lad("post_rst");
        chk("post_rst_addr", cap_addr, 5);

`ifdef LPC_SEQ_TIMEOUT_EN
        // No ack: 15 short waits, error, turnaround
        clear_log();
        ack_delay = 1000;
        host_io(1'b0, 16'h03F8, 8'h00);
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hF);
        check_lad("tmo");
        chk("tmo_req_low", reg_req, 0);
`else
        // Long wait: SYNC keeps short-waiting past any timeout
        clear_log();
        ack_delay = 20;
        rd_val    = 8'h99;
        host_io(1'b0, 16'h03F8, 8'h00);
        for (int i = 0; i < 19; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h9);
        exp_q.push_back(4'h9);
        exp_q.push_back(4'hF);
        check_lad("longwait");
`endif
        chk("end_oe", lpc_ad_oe, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
